// File: rtl/router_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared state encoding, address constants and output decode
//                for the router controller FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

    // Controller states; all eight 3-bit codes are assigned.
    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    // Header address value that names no output port.
    localparam logic [1:0] c_addr_invalid = 2'b11;

    // Bundle of all controller outputs, registered together.
    typedef struct packed {
        logic detect_add;
        logic lfd_state;
        logic ld_state;
        logic full_state;
        logic laf_state;
        logic rst_int_reg;
        logic write_enb_reg;
        logic busy;
    } router_out_t;

    // Moore decode: outputs depend only on the state.
    function automatic router_out_t decode_outputs(input router_state_e state);
        router_out_t o;
        o               = '0;
        o.detect_add    = (state == DECODE_ADDRESS);
        o.lfd_state     = (state == LOAD_FIRST_DATA);
        o.ld_state      = (state == LOAD_DATA);
        o.full_state    = (state == FIFO_FULL_STATE);
        o.laf_state     = (state == LOAD_AFTER_FULL);
        o.rst_int_reg   = (state == CHECK_PARITY_ERROR);
        o.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                          (state == LOAD_AFTER_FULL);
        o.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
        return o;
    endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : router_fsm
//  Description : Packet router controller. Decodes the header address, waits
//                for the target FIFO to drain, sequences payload/parity loads
//                and throttles the source while the FIFO is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module router_fsm
    import router_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       packet_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       full_state,
    output logic       laf_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic       busy
);

    router_state_e r_state;
    router_state_e w_next;
    logic [1:0]    r_addr;
    router_out_t   r_out;

    // Port 3 does not exist; its slot reads as never-empty / never-reset.
    logic [3:0] w_empty_vec;
    logic [3:0] w_soft_vec;
    logic       w_hdr_ok;
    logic       w_soft_hit;

    assign w_empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign w_soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
    assign w_hdr_ok    = packet_valid && (data_in != c_addr_invalid);
    assign w_soft_hit  = w_soft_vec[r_addr];

    // Next-state selection; a soft reset on the active port wins over all moves.
    always_comb begin
        w_next = r_state;
        if (w_soft_hit) begin
            w_next = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (w_hdr_ok)
                        w_next = w_empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (w_empty_vec[r_addr])
                        w_next = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: w_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        w_next = FIFO_FULL_STATE;
                    else if (!packet_valid)
                        w_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        w_next = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        w_next = DECODE_ADDRESS;
                    else if (low_packet_valid)
                        w_next = LOAD_PARITY;
                    else
                        w_next = LOAD_DATA;
                end
                LOAD_PARITY:        w_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                default:            w_next = DECODE_ADDRESS;
            endcase
        end
    end

    // State, latched address and registered Moore outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= DECODE_ADDRESS;
            r_addr  <= 2'd0;
            r_out   <= decode_outputs(DECODE_ADDRESS);
        end else begin
            r_state <= w_next;
            if ((r_state == DECODE_ADDRESS) && w_hdr_ok)
                r_addr <= data_in;
            r_out   <= decode_outputs(w_next);
        end
    end

    assign detect_add    = r_out.detect_add;
    assign lfd_state     = r_out.lfd_state;
    assign ld_state      = r_out.ld_state;
    assign full_state    = r_out.full_state;
    assign laf_state     = r_out.laf_state;
    assign rst_int_reg   = r_out.rst_int_reg;
    assign write_enb_reg = r_out.write_enb_reg;
    assign busy          = r_out.busy;

endmodule : router_fsm
`default_nettype wire

// File: tb/tb_router_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_fsm
//  Description : Self-checking bench for router_fsm with a behavioural
//                packet-phase model, directed scenarios and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       packet_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, full_state;
    logic       laf_state, rst_int_reg, write_enb_reg, busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    router_fsm dut (
        .clk              (clk),
        .rst              (rst),
        .packet_valid     (packet_valid),
        .data_in          (data_in),
        .fifo_full        (fifo_full),
        .fifo_empty_0     (fifo_empty_0),
        .fifo_empty_1     (fifo_empty_1),
        .fifo_empty_2     (fifo_empty_2),
        .soft_reset_0     (soft_reset_0),
        .soft_reset_1     (soft_reset_1),
        .soft_reset_2     (soft_reset_2),
        .parity_done      (parity_done),
        .low_packet_valid (low_packet_valid),
        .detect_add       (detect_add),
        .lfd_state        (lfd_state),
        .ld_state         (ld_state),
        .full_state       (full_state),
        .laf_state        (laf_state),
        .rst_int_reg      (rst_int_reg),
        .write_enb_reg    (write_enb_reg),
        .busy             (busy)
    );

    // Packet phases of the reference model.
    localparam int P_DEC  = 0;  // waiting for a header
    localparam int P_WAIT = 1;  // header accepted, target FIFO not yet empty
    localparam int P_LFD  = 2;  // writing the header byte
    localparam int P_LD   = 3;  // streaming payload
    localparam int P_FULL = 4;  // stalled on a full FIFO
    localparam int P_LAF  = 5;  // resuming after the stall
    localparam int P_LP   = 6;  // writing the parity byte
    localparam int P_CHK  = 7;  // parity check

    // Expected {detect,lfd,ld,full,laf,rst_int,wen,busy} for each phase.
    logic [7:0] exp_out [8];
    int         m_phase;
    logic [1:0] m_addr;

    initial begin
        exp_out[P_DEC]  = 8'b1000_0000;
        exp_out[P_WAIT] = 8'b0000_0001;
        exp_out[P_LFD]  = 8'b0100_0001;
        exp_out[P_LD]   = 8'b0010_0010;
        exp_out[P_FULL] = 8'b0001_0001;
        exp_out[P_LAF]  = 8'b0000_1011;
        exp_out[P_LP]   = 8'b0000_0011;
        exp_out[P_CHK]  = 8'b0000_0101;
    end

    function automatic logic [7:0] dut_vec();
        return {detect_add, lfd_state, ld_state, full_state,
                laf_state, rst_int_reg, write_enb_reg, busy};
    endfunction

    // Advance the model by one clock using the inputs presented at this edge.
    task automatic model_step();
        int         np;
        logic [1:0] na;
        logic [2:0] fe;
        logic [2:0] sr;
        if (rst) begin
            m_phase = P_DEC;
            m_addr  = 2'd0;
            return;
        end
        fe = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        sr = {soft_reset_2, soft_reset_1, soft_reset_0};
        np = m_phase;
        na = m_addr;
        if (m_phase == P_DEC && packet_valid && data_in != 2'd3)
            na = data_in;
        if (m_addr != 2'd3 && sr[m_addr]) begin
            np = P_DEC;
        end else begin
            case (m_phase)
                P_DEC:  if (packet_valid && data_in != 2'd3) np = fe[data_in] ? P_LFD : P_WAIT;
                P_WAIT: if (fe[m_addr]) np = P_LFD;
                P_LFD:  np = P_LD;
                P_LD:   if (fifo_full) np = P_FULL; else if (!packet_valid) np = P_LP;
                P_FULL: if (!fifo_full) np = P_LAF;
                P_LAF:  np = parity_done ? P_DEC : (low_packet_valid ? P_LP : P_LD);
                P_LP:   np = P_CHK;
                P_CHK:  np = fifo_full ? P_FULL : P_DEC;
                default: np = P_DEC;
            endcase
        end
        m_phase = np;
        m_addr  = na;
    endtask

    task automatic chk_model(input string name);
        n_checks++;
        if (dut_vec() !== exp_out[m_phase]) begin
            n_fail++;
            $display("FAIL %s: outputs got %b expected %b (phase %0d)",
                     name, dut_vec(), exp_out[m_phase], m_phase);
        end
    endtask

    task automatic lit(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        model_step();
        #1;
        chk_model(name);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; packet_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        parity_done = 1'b0; low_packet_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        m_phase = P_DEC;
        m_addr  = 2'd0;

        // Reset held two cycles.
        rst = 1'b1;
        tick("reset1");
        tick("reset2");
        rst = 1'b0;
        lit("reset_outputs", dut_vec(), 8'b1000_0000);
        lit("reset_phase", 8'(m_phase), 8'(P_DEC));

        // Packet to port 1, empty FIFO, three payload bytes.
        packet_valid = 1'b1; data_in = 2'd1;
        tick("p1_hdr");
        lit("p1_lfd", dut_vec(), 8'b0100_0001);
        data_in = 2'd2;
        for (int i = 0; i < 3; i++) begin
            tick("p1_ld");
            lit("p1_ld_lit", dut_vec(), 8'b0010_0010);
        end
        packet_valid = 1'b0;
        tick("p1_lp");
        lit("p1_lp_lit", 8'(m_phase), 8'(P_LP));
        tick("p1_chk");
        lit("p1_rst_int", {7'd0, rst_int_reg}, 8'd1);
        tick("p1_dec");
        lit("p1_back_dec", {7'd0, detect_add}, 8'd1);

        // Packet to port 2 that must wait four cycles for the FIFO.
        packet_valid = 1'b1; data_in = 2'd2; fifo_empty_2 = 1'b0;
        tick("p2_hdr");
        data_in = 2'd0;
        for (int i = 0; i < 3; i++) tick("p2_wait");
        lit("p2_wait_busy", dut_vec(), 8'b0000_0001);
        fifo_empty_2 = 1'b1;
        tick("p2_lfd");
        lit("p2_lfd_lit", {7'd0, lfd_state}, 8'd1);
        tick("p2_ld");

        // FIFO full for three cycles during payload.
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("full");
            lit("full_wen0", dut_vec(), 8'b0001_0001);
        end
        fifo_full = 1'b0;
        tick("laf");
        lit("laf_wen1", dut_vec(), 8'b0000_1011);
        tick("laf_to_ld");
        lit("laf_ld", {7'd0, ld_state}, 8'd1);
        packet_valid = 1'b0;
        tick("p2_lp");
        tick("p2_chk");
        tick("p2_dec");

        // Invalid address header is dropped.
        packet_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick("bad_addr");
            lit("bad_addr_stay", dut_vec(), 8'b1000_0000);
        end

        // Soft resets: foreign port ignored, own port aborts.
        data_in = 2'd0;
        tick("p0_hdr");
        tick("p0_ld");
        soft_reset_1 = 1'b1;
        tick("sr1_ignored");
        lit("sr1_ld", {7'd0, ld_state}, 8'd1);
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        tick("sr0_abort");
        lit("sr0_dec", dut_vec(), 8'b1000_0000);
        soft_reset_0 = 1'b0;

        // Reset in the middle of a packet.
        data_in = 2'd1;
        tick("mid_hdr");
        tick("mid_ld");
        rst = 1'b1; soft_reset_1 = 1'b1;
        tick("mid_rst");
        lit("mid_rst_dec", dut_vec(), 8'b1000_0000);
        idle_inputs();

        // Random traffic checked against the model every cycle.
        for (int i = 0; i < 4000; i++) begin
            rst              = ($urandom_range(0, 99) == 0);
            packet_valid     = ($urandom_range(0, 3) != 0);
            data_in          = 2'($urandom_range(0, 3));
            fifo_full        = ($urandom_range(0, 3) == 0);
            fifo_empty_0     = ($urandom_range(0, 1) == 0);
            fifo_empty_1     = ($urandom_range(0, 1) == 0);
            fifo_empty_2     = ($urandom_range(0, 1) == 0);
            soft_reset_0     = ($urandom_range(0, 19) == 0);
            soft_reset_1     = ($urandom_range(0, 19) == 0);
            soft_reset_2     = ($urandom_range(0, 19) == 0);
            parity_done      = ($urandom_range(0, 3) == 0);
            low_packet_valid = ($urandom_range(0, 3) == 0);
            tick("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_router_fsm
`default_nettype wire
